btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Front-end conditioning for all push-button inputs ahead of the toggle bank and the load/start FSM.
//  Per button: 2-flop synchroniser, counter-based debounce filter, registered rising/falling one-cycle pulses.
//  Consumers use btn_rise as the single "press" event.
//  Replaces raw pb_in/load_btn/start_btn wiring into the input and control stages.
// PARAMETERS
//  N_BTN         18  number of buttons; bits [15:0] data, [16] load, [17] start (indices in btn_pkg)
//  DEBOUNCE_CYC  4   consecutive differing synchronised samples required to accept a new level; legal 1..255
//  CNT_W         $clog2(DEBOUNCE_CYC+1)  debounce counter width (derived, not overridden)
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  nRST       in   1      asynchronous active-low reset
//  btn_raw    in   N_BTN  raw button levels, active high, asynchronous to clk
//  btn_level  out  N_BTN  debounced stable level per button
//  btn_rise   out  N_BTN  one-cycle pulse: btn_level went 0->1 this cycle
//  btn_fall   out  N_BTN  one-cycle pulse: btn_level went 1->0 this cycle
//  any_rise   out  1      registered OR of all btn_rise bits; same cycle as the rise
// BEHAVIOUR
//  Reset (nRST=0, async): sync1, sync2, cnt, btn_level, btn_rise, btn_fall, any_rise all 0. No output pulses during reset.
//  Per bit, every clk edge:
//   - sync1<=btn_raw; sync2<=sync1.
//   - If sync2==btn_level: cnt<=0 (a glitch shorter than DEBOUNCE_CYC samples is discarded).
//   - If sync2!=btn_level and cnt<DEBOUNCE_CYC-1: cnt<=cnt+1.
//   - If sync2!=btn_level and cnt==DEBOUNCE_CYC-1: btn_level<=sync2, cnt<=0.
//   - btn_rise<=accept & sync2; btn_fall<=accept & ~sync2 (accept = the flip condition above).
//     Both are therefore high exactly in the cycle btn_level changes.
//  Latency: raw change held from before edge 1 -> btn_level/btn_rise update at edge 2+DEBOUNCE_CYC.
//   Pulses drop at the next edge.
//  DEBOUNCE_CYC=1: level accepted on first differing synchronised sample (latency 3 edges).
//  Held button: exactly one btn_rise per press; btn_rise never repeats while held.
//  Simultaneous: bits independent; several rises in one cycle allowed; any_rise high once for that cycle.
//  Reset mid-debounce: counter state lost. A button still held after release of nRST is treated as a fresh press.
//   It produces btn_rise at edge 2+DEBOUNCE_CYC after reset release.
//  btn_rise and btn_fall on the same bit are mutually exclusive in any cycle.
//  Counter saturates by construction; it never wraps.
// STRUCTURE
//  btn_pkg: N_BTN_DEF=18, DEBOUNCE_DEF=4, IDX_LOAD=16, IDX_START=17, DATA_W=16.
//  Sub-module debounce_cell: one bit holding sync1, sync2, cnt, level, rise, fall.
//   It takes the same DEBOUNCE_CYC parameter and is generated N_BTN times.
//  Top level: the generate loop plus the any_rise register (registered from the OR of the cells' accept & sync2 terms).
// TESTING
//  1. Reset, btn_raw=0 for 20 cycles.
//     -> all outputs 0, no pulses.
//  2. btn_raw[0]=1 held (DEBOUNCE_CYC=4).
//     -> btn_level[0]=1 and btn_rise[0]=any_rise=1 after edge 6; pulses 0 after edge 7.
//     -> Release gives btn_fall[0] after 6 edges.
//  3. btn_raw[5] high for 3 cycles, then low (glitch).
//     -> btn_level[5] stays 0; no rise; cnt returns to 0.
//  4. btn_raw[16] and btn_raw[17] set in the same cycle.
//     -> both rise bits in the same cycle; any_rise single cycle high.
//  5. btn_raw[3] held; nRST pulsed low at edge 10 and released.
//     -> outputs 0 immediately; btn_rise[3] again 6 edges after release.
//  6. Instance with DEBOUNCE_CYC=1; toggle btn_raw[7] every 4 cycles.
//     -> level follows with 3-edge latency; alternating rise/fall pulses.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared button-bank constants and debounce counter sizing
package btn_pkg;
  localparam int N_BTN_DEF    = 18;
  localparam int DEBOUNCE_DEF = 4;
  localparam int IDX_LOAD     = 16;
  localparam int IDX_START    = 17;
  localparam int DATA_W       = 16;
  function automatic int cnt_width(input int deb);
    return $clog2(deb + 1);
  endfunction
endpackage

// File: rtl/btn_conditioner_debounce_cell.sv
// debounce_cell: one-bit synchroniser, counter debounce filter and registered edge pulses
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic nRST,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);
  localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  logic sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d, rise_q, rise_d, fall_q, fall_d, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // a run of differing samples shorter than DEBOUNCE_CYC restarts from zero
  always_comb begin
    accept  = (sync2_q != level_q) && (cnt_q == CNT_MAX);
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = (sync2_q == level_q || accept) ? '0 : cnt_q + 1'b1;
    level_d = accept ? sync2_q : level_q;
    rise_d  = accept & sync2_q;
    fall_d  = accept & ~sync2_q;
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = rise_d;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button debounce bank with registered any-press flag
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_DEF
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             any_rise
);
  logic [N_BTN-1:0] press;
  logic any_rise_q, any_rise_d;
  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cell (
      .clk  (clk),
      .nRST (nRST),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i]),
      .fall (btn_fall[i]),
      .press(press[i])
    );
  end
  always_comb any_rise_d = |press;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) any_rise_q <= 1'b0;
    else any_rise_q <= any_rise_d;
  end
  assign any_rise = any_rise_q;
endmodule
